// File: rtl/write_ptr_full.sv
// Write-domain pointer and full-flag generator for an asynchronous FIFO.
// Keeps the binary and Gray write pointers. Compares the next Gray pointer with
// the read pointer, which arrives already synchronized to write_clk.
// Produces registered full, almost_full, fill level and a sticky overflow flag.
module write_ptr_full #(
    parameter int address   = 3,
    parameter int AF_MARGIN = 2
) (
    input  logic               write_clk,
    input  logic               write_rst_n,
    input  logic               write_en,
    input  logic [address:0]   sync_read_ptr,
    output logic [address-1:0] write_addr,
    output logic [address:0]   write_ptr,
    output logic               write_accept,
    output logic               full,
    output logic               almost_full,
    output logic [address:0]   write_level,
    output logic               overflow
);

    localparam int PW    = address + 1;
    localparam int DEPTH = 1 << address;
    localparam logic [address:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

    logic [address:0] wbin;
    logic [address:0] wbin_next;
    logic [address:0] wgray_next;
    logic [address:0] rbin;
    logic [address:0] full_pattern;
    logic [address:0] level_next;
    logic             full_next;
    logic             almost_full_next;

    // A write is taken only while the FIFO is not full; this also gates the memory.
    assign write_accept = write_en & ~full;

    // Advance the pointer by the accepted write. Wrap-around is the natural modulo of the width.
    always_comb begin
        wbin_next  = wbin + {{address{1'b0}}, write_accept};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
    end

    // Gray-to-binary conversion of the synchronized read pointer.
    // Each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin          = '0;
        rbin[address] = sync_read_ptr[address];
        for (int i = address - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ sync_read_ptr[i];
        end
    end

    // Full in Gray space: the top two bits are inverted relative to the read pointer and the
    // rest match. Using the next pointer makes full rise on the edge that writes the last slot.
    always_comb begin
        full_pattern     = {~sync_read_ptr[address:address-1], sync_read_ptr[address-2:0]};
        full_next        = (wgray_next == full_pattern);
        level_next       = wbin_next - rbin;
        almost_full_next = (level_next >= AF_THRESH);
    end

    // Pointer registers. The binary pointer's low bits address the memory directly.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            wbin      <= '0;
            write_ptr <= '0;
        end else begin
            wbin      <= wbin_next;
            write_ptr <= wgray_next;
        end
    end

    assign write_addr = wbin[address-1:0];

    // Status flags. The read pointer is stale, so these can only overstate occupancy, never understate it.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            full        <= 1'b0;
            almost_full <= 1'b0;
            write_level <= '0;
        end else begin
            full        <= full_next;
            almost_full <= almost_full_next;
            write_level <= level_next;
        end
    end

    // Sticky record of a write attempted while full; only reset clears it.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow | (write_en & full);
        end
    end

endmodule

// File: tb/tb_write_ptr_full.sv
// Directed bench for write_ptr_full (address=3, AF_MARGIN=2).
// The stimulus pushes the expected post-edge state into a queue.
// A monitor pops it one step after each rising edge and compares.
module tb_write_ptr_full;

    logic       write_clk;
    logic       write_rst_n;
    logic       write_en;
    logic [3:0] sync_read_ptr;
    logic [2:0] write_addr;
    logic [3:0] write_ptr;
    logic       write_accept;
    logic       full;
    logic       almost_full;
    logic [3:0] write_level;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] ptr;
        logic [2:0] addr;
        logic       full;
        logic       af;
        logic [3:0] lvl;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];

    write_ptr_full #(.address(3), .AF_MARGIN(2)) dut (
        .write_clk    (write_clk),
        .write_rst_n  (write_rst_n),
        .write_en     (write_en),
        .sync_read_ptr(sync_read_ptr),
        .write_addr   (write_addr),
        .write_ptr    (write_ptr),
        .write_accept (write_accept),
        .full         (full),
        .almost_full  (almost_full),
        .write_level  (write_level),
        .overflow     (overflow)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    function automatic logic [3:0] gray(input int n);
        logic [3:0] b;
        b = n[3:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_write_ptr"},   32'(write_ptr),   32'd0);
        chk({tag, "_write_addr"},  32'(write_addr),  32'd0);
        chk({tag, "_full"},        32'(full),        32'd0);
        chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
        chk({tag, "_write_level"}, 32'(write_level), 32'd0);
        chk({tag, "_overflow"},    32'(overflow),    32'd0);
    endtask

    // Drive one cycle of stimulus, check the combinational accept, and queue the expected registered state.
    task automatic step(input logic en, input logic [3:0] srp, input logic e_acc,
                        input logic [3:0] e_ptr, input logic e_full, input logic e_af,
                        input logic [3:0] e_lvl, input logic e_ovf);
        exp_t       e;
        logic [3:0] b;
        @(negedge write_clk);
        write_en      = en;
        sync_read_ptr = srp;
        #1;
        chk("write_accept", 32'(write_accept), 32'(e_acc));
        b      = g2b(e_ptr);
        e.ptr  = e_ptr;
        e.addr = b[2:0];
        e.full = e_full;
        e.af   = e_af;
        e.lvl  = e_lvl;
        e.ovf  = e_ovf;
        exp_q.push_back(e);
    endtask

    // Monitor: registered outputs are settled one time unit after each rising edge.
    always @(posedge write_clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("write_ptr",   32'(write_ptr),   32'(e.ptr));
            chk("write_addr",  32'(write_addr),  32'(e.addr));
            chk("full",        32'(full),        32'(e.full));
            chk("almost_full", 32'(almost_full), 32'(e.af));
            chk("write_level", 32'(write_level), 32'(e.lvl));
            chk("overflow",    32'(overflow),    32'(e.ovf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        // Reset held with write requests and a changing read pointer: nothing may move.
        write_rst_n   = 1'b0;
        write_en      = 1'b1;
        sync_read_ptr = 4'($urandom);
        repeat (4) begin
            @(negedge write_clk);
            sync_read_ptr = 4'($urandom);
            #1 check_zero("reset");
        end
        @(negedge write_clk);
        write_rst_n   = 1'b1;
        write_en      = 1'b0;
        sync_read_ptr = 4'b0000;

        // Idle after release: the pointer stays at zero.
        step(0, 4'b0000, 0, 4'b0000, 0, 0, 4'd0, 0);
        step(0, 4'b0000, 0, 4'b0000, 0, 0, 4'd0, 0);

        // Fill to full, then two blocked writes.
        step(1, 4'b0000, 1, 4'b0001, 0, 0, 4'd1, 0);
        step(1, 4'b0000, 1, 4'b0011, 0, 0, 4'd2, 0);
        step(1, 4'b0000, 1, 4'b0010, 0, 0, 4'd3, 0);
        step(1, 4'b0000, 1, 4'b0110, 0, 0, 4'd4, 0);
        step(1, 4'b0000, 1, 4'b0111, 0, 0, 4'd5, 0);
        step(1, 4'b0000, 1, 4'b0101, 0, 1, 4'd6, 0);
        step(1, 4'b0000, 1, 4'b0100, 0, 1, 4'd7, 0);
        step(1, 4'b0000, 1, 4'b1100, 1, 1, 4'd8, 0);
        step(1, 4'b0000, 0, 4'b1100, 1, 1, 4'd8, 1);
        step(1, 4'b0000, 0, 4'b1100, 1, 1, 4'd8, 1);

        // Three slots freed (read pointer Gray(3)), then refill to full.
        step(0, 4'b0010, 0, 4'b1100, 0, 0, 4'd5, 1);
        step(1, 4'b0010, 1, 4'b1101, 0, 1, 4'd6, 1);
        step(1, 4'b0010, 1, 4'b1111, 0, 1, 4'd7, 1);
        step(1, 4'b0010, 1, 4'b1110, 1, 1, 4'd8, 1);

        // Read pointer to Gray(6): level 5, with overflow still set.
        step(0, 4'b0101, 0, 4'b1110, 0, 0, 4'd5, 1);

        // Asynchronous reset in mid-cycle clears everything before the next edge.
        @(negedge write_clk);
        #2 write_rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge write_clk);
        write_rst_n   = 1'b1;
        sync_read_ptr = 4'b0000;

        // Wrap: write one entry, then let the reader catch up; 20 writes pass the pointer wrap.
        for (int k = 0; k < 20; k++) begin
            step(1, gray(k),     1, gray(k + 1), 0, 0, 4'd1, 0);
            step(0, gray(k + 1), 0, gray(k + 1), 0, 0, 4'd0, 0);
        end

        // Reader parked at binary 4; fill to level 7.
        for (int j = 1; j <= 7; j++) begin
            step(1, gray(4), 1, gray(4 + j), 0, (j >= 6), 4'(j), 0);
        end
        // A write in the same cycle the reader frees one slot: the level holds at 7.
        step(1, gray(5), 1, gray(12), 0, 1, 4'd7, 0);

        @(negedge write_clk);
        write_en = 1'b0;
        repeat (3) @(posedge write_clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
